// File: rtl/object_pkg.sv
// rtl/object_pkg.sv - spawn record layout, field widths and sequencer state encoding
package object_pkg;

    localparam int REC_W     = 67;
    localparam int END_BIT   = 66;
    localparam int DELAY_LSB = 58;
    localparam int DIR_LSB   = 55;
    localparam int POSX_LSB  = 45;
    localparam int POSY_LSB  = 35;
    localparam int W_LSB     = 25;
    localparam int H_LSB     = 15;
    localparam int SPEED_LSB = 10;
    localparam int DTIME_LSB = 2;
    localparam int DTRIG_LSB = 0;

    localparam int DELAY_W = 8;
    localparam int DIR_W   = 3;
    localparam int POS_W   = 10;
    localparam int SIZE_W  = 10;
    localparam int SPEED_W = 5;
    localparam int DTIME_W = 8;
    localparam int DTRIG_W = 2;
    localparam int CNT_W   = 8;

    // Object fields in record order; occupies record bits [OBJ_W-1:0]
    typedef struct packed {
        logic [DIR_W-1:0]   direction;
        logic [POS_W-1:0]   pos_x;
        logic [POS_W-1:0]   pos_y;
        logic [SIZE_W-1:0]  w;
        logic [SIZE_W-1:0]  h;
        logic [SPEED_W-1:0] speed;
        logic [DTIME_W-1:0] destroy_time;
        logic [DTRIG_W-1:0] destroy_trigger;
    } spawn_obj_t;

    localparam int OBJ_W = $bits(spawn_obj_t);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_WAIT_DELAY,
        ST_REQUEST,
        ST_RELEASE,
        ST_DONE
    } seq_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/spawn_delay_timer.sv
// rtl/spawn_delay_timer.sv - centisecond tick counter compared against a record's delay
module spawn_delay_timer
    import object_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               tick,
    input  logic [DELAY_W-1:0] delay_cs,
    output logic               elapsed
);

    logic [DELAY_W-1:0] count_q, count_d;

    assign elapsed = (count_q == delay_cs);

    // Count ticks until the delay is reached; holding at the target avoids wrap-around
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick && !elapsed) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/object_spawn_sequencer.sv
// rtl/object_spawn_sequencer.sv - pattern ROM walker driving the object load handshake (optional SPAWN_TIMEOUT_EN)
module object_spawn_sequencer
    import object_pkg::*;
#(
    parameter int ROM_DEPTH      = 64,
    parameter int ADDR_W         = 6,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk_calculation,
    input  logic               reset,
    input  logic               start,
    input  logic               centi_tick,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [REC_W-1:0]   rom_data,
    output logic [DIR_W-1:0]   object_movement_direction,
    output logic [POS_W-1:0]   object_pos_x,
    output logic [POS_W-1:0]   object_pos_y,
    output logic [SIZE_W-1:0]  object_w,
    output logic [SIZE_W-1:0]  object_h,
    output logic [SPEED_W-1:0] object_speed,
    output logic [DTIME_W-1:0] object_destroy_time,
    output logic [DTRIG_W-1:0] object_destroy_trigger,
    output logic               sync_object_position,
    input  logic               update_object_position,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   spawn_count,
    output logic [CNT_W-1:0]   drop_count
);

    seq_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    spawn_obj_t         obj_q, obj_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic               sync_q, sync_d;
    logic [CNT_W-1:0]   spawn_cnt_q, spawn_cnt_d;
    logic               delay_elapsed;
    logic               timed_out;
    logic               start_accept;
    logic               last_addr;

    assign start_accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_addr    = (rom_addr_q == ADDR_W'(ROM_DEPTH - 1));

    spawn_delay_timer u_delay_timer (
        .clk      (clk_calculation),
        .rst      (reset),
        .clear    (state_q == ST_LOAD),
        .tick     (centi_tick && (state_q == ST_WAIT_DELAY)),
        .delay_cs (delay_q),
        .elapsed  (delay_elapsed)
    );

`ifdef SPAWN_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    assign timed_out  = (state_q == ST_REQUEST) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign drop_count = drop_cnt_q;

    // Count cycles spent waiting for an ack; an unanswered request is dropped
    always_comb begin
        to_cnt_d   = '0;
        drop_cnt_d = drop_cnt_q;
        if ((state_q == ST_REQUEST) && !update_object_position) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        if (start_accept) begin
            drop_cnt_d = '0;
        end else if (timed_out && !update_object_position) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    // Timeout and drop counter registers
    always_ff @(posedge clk_calculation or posedge reset) begin
        if (reset) begin
            to_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            to_cnt_q   <= to_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end
`else
    // Requests wait forever, so nothing is ever dropped
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timed_out          = 1'b0;
    assign drop_count         = '0;
`endif

    // Sequencer next state: walk records, wait delay, run the sync/update handshake
    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        obj_d       = obj_q;
        delay_d     = delay_q;
        spawn_cnt_d = spawn_cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    rom_addr_d  = '0;
                    spawn_cnt_d = '0;
                    state_d     = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                obj_d   = spawn_obj_t'(rom_data[OBJ_W-1:0]);
                delay_d = rom_data[DELAY_LSB +: DELAY_W];
                state_d = rom_data[END_BIT] ? ST_DONE : ST_WAIT_DELAY;
            end
            ST_WAIT_DELAY: begin
                if (delay_elapsed) begin
                    state_d = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (update_object_position) begin
                    spawn_cnt_d = sat_inc(spawn_cnt_q);
                    state_d     = ST_RELEASE;
                end else if (timed_out) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!update_object_position) begin
                    if (last_addr) begin
                        state_d = ST_DONE;
                    end else begin
                        rom_addr_d = rom_addr_q + 1'b1;
                        state_d    = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        sync_d = (state_d != ST_REQUEST);
    end

    // State and datapath registers; sync idles high so reset releases the runtime at once
    always_ff @(posedge clk_calculation or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rom_addr_q  <= '0;
            obj_q       <= '0;
            delay_q     <= '0;
            sync_q      <= 1'b1;
            spawn_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            obj_q       <= obj_d;
            delay_q     <= delay_d;
            sync_q      <= sync_d;
            spawn_cnt_q <= spawn_cnt_d;
        end
    end

    assign rom_addr                  = rom_addr_q;
    assign object_movement_direction = obj_q.direction;
    assign object_pos_x              = obj_q.pos_x;
    assign object_pos_y              = obj_q.pos_y;
    assign object_w                  = obj_q.w;
    assign object_h                  = obj_q.h;
    assign object_speed              = obj_q.speed;
    assign object_destroy_time       = obj_q.destroy_time;
    assign object_destroy_trigger    = obj_q.destroy_trigger;
    assign sync_object_position      = sync_q;
    assign busy                      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done                      = (state_q == ST_DONE);
    assign spawn_count               = spawn_cnt_q;

endmodule

// File: tb/tb_object_spawn_sequencer.sv
// tb/tb_object_spawn_sequencer.sv - self-checking bench for object_spawn_sequencer
module tb_object_spawn_sequencer;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int TO    = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        centi_tick = 1'b0;
    logic        update = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [66:0] rom_q;
    logic [2:0]  dir;
    logic [9:0]  pos_x, pos_y, obj_w, obj_h;
    logic [4:0]  speed;
    logic [7:0]  dtime;
    logic [1:0]  dtrig;
    logic        sync, busy, done;
    logic [7:0]  spawn_count, drop_count;
    logic [57:0] obj_bus;

    logic [66:0] rom [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom[rom_addr];

    assign obj_bus = {dir, pos_x, pos_y, obj_w, obj_h, speed, dtime, dtrig};

    object_spawn_sequencer #(
        .ROM_DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_calculation           (clk),
        .reset                     (reset),
        .start                     (start),
        .centi_tick                (centi_tick),
        .rom_addr                  (rom_addr),
        .rom_data                  (rom_q),
        .object_movement_direction (dir),
        .object_pos_x              (pos_x),
        .object_pos_y              (pos_y),
        .object_w                  (obj_w),
        .object_h                  (obj_h),
        .object_speed              (speed),
        .object_destroy_time       (dtime),
        .object_destroy_trigger    (dtrig),
        .sync_object_position      (sync),
        .update_object_position    (update),
        .busy                      (busy),
        .done                      (done),
        .spawn_count               (spawn_count),
        .drop_count                (drop_count)
    );

    function automatic logic [57:0] rand_fields();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[57:0];
    endfunction

    function automatic logic [66:0] mk_rec(input logic e, input logic [7:0] d, input logic [57:0] f);
        return {e, d, f};
    endfunction

    task automatic fill_rom_end();
        for (int i = 0; i < DEPTH; i++) rom[i] = mk_rec(1'b1, 8'd0, rand_fields());
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        fill_rom_end();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (sync !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl sync=%b busy=%b done=%b expected 1/0/0", sync, busy, done);
        end
        n_checks++;
        if (rom_addr !== '0 || spawn_count !== 8'd0 || drop_count !== 8'd0 || obj_bus !== '0) begin
            n_fail++;
            $display("FAIL reset_data addr=%0d spawn=%0d drop=%0d obj=%h expected all 0",
                     rom_addr, spawn_count, drop_count, obj_bus);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || sync !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_after_reset busy=%b sync=%b expected 0/1", busy, sync);
        end
    endtask

    task automatic test_basic();
        logic [57:0] f;
        bit ok;
        fill_rom_end();
        f = rand_fields();
        f[54:45] = 10'd100;
        rom[0] = mk_rec(1'b0, 8'd0, f);
        do_start();
        n_checks++;
        if (busy !== 1'b1 || rom_addr !== '0 || sync !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_fetch busy=%b addr=%0d sync=%b expected 1/0/1", busy, rom_addr, sync);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (sync !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_sync_early got %b expected 1", sync);
        end
        @(negedge clk);
        n_checks++;
        if (sync !== 1'b0 || pos_x !== 10'd100 || obj_bus !== f) begin
            n_fail++;
            $display("FAIL basic_request sync=%b pos_x=%0d obj=%h expected 0/100/%h", sync, pos_x, obj_bus, f);
        end
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        n_checks++;
        if (sync !== 1'b1 || spawn_count !== 8'd1) begin
            n_fail++;
            $display("FAIL basic_ack sync=%b spawn=%0d expected 1/1", sync, spawn_count);
        end
        wait_done(50, ok);
        n_checks++;
        if (!ok || busy !== 1'b0 || spawn_count !== 8'd1 || rom_addr !== AW'(1)) begin
            n_fail++;
            $display("FAIL basic_done done=%b busy=%b spawn=%0d addr=%0d expected 1/0/1/1",
                     done, busy, spawn_count, rom_addr);
        end
    endtask

    task automatic test_delay();
        logic [57:0] f;
        int gap;
        bit ok;
        bit early;
        fill_rom_end();
        f = rand_fields();
        rom[0] = mk_rec(1'b0, 8'd5, f);
        do_start();
        n_checks++;
        if (spawn_count !== 8'd0) begin
            n_fail++;
            $display("FAIL delay_count_clear spawn=%0d expected 0", spawn_count);
        end
        repeat (2) @(negedge clk);
        early = 1'b0;
        for (int i = 0; i < 5; i++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                centi_tick = 1'b0;
                @(negedge clk);
                if (sync !== 1'b1) early = 1'b1;
            end
            if (i == 2) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                n_checks++;
                if (rom_addr !== '0 || busy !== 1'b1 || sync !== 1'b1) begin
                    n_fail++;
                    $display("FAIL delay_start_ignored addr=%0d busy=%b sync=%b expected 0/1/1",
                             rom_addr, busy, sync);
                end
            end
            centi_tick = 1'b1;
            @(negedge clk);
            centi_tick = 1'b0;
            if (sync !== 1'b1) early = 1'b1;
        end
        n_checks++;
        if (early) begin
            n_fail++;
            $display("FAIL delay_early sync fell before the 5th tick, expected it held at 1");
        end
        @(negedge clk);
        n_checks++;
        if (sync !== 1'b0 || obj_bus !== f) begin
            n_fail++;
            $display("FAIL delay_fall sync=%b obj=%h expected 0/%h", sync, obj_bus, f);
        end
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        wait_done(50, ok);
        n_checks++;
        if (!ok || spawn_count !== 8'd1) begin
            n_fail++;
            $display("FAIL delay_done done=%b spawn=%0d expected 1/1", done, spawn_count);
        end
    endtask

    task automatic test_long_ack();
        logic [57:0] f0, f1;
        bit ok;
        bit bad;
        fill_rom_end();
        f0 = rand_fields();
        f1 = rand_fields();
        rom[0] = mk_rec(1'b0, 8'd0, f0);
        rom[1] = mk_rec(1'b0, 8'd0, f1);
        do_start();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sync !== 1'b0) begin
            n_fail++;
            $display("FAIL long_req sync=%b expected 0", sync);
        end
        update = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (sync !== 1'b1 || rom_addr !== '0 || spawn_count !== 8'd1 || obj_bus !== f0) bad = 1'b1;
        end
        update = 1'b0;
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL long_hold sync=%b addr=%0d spawn=%0d expected 1/0/1 with fields held",
                     sync, rom_addr, spawn_count);
        end
        @(negedge clk);
        n_checks++;
        if (rom_addr !== AW'(1) || sync !== 1'b1) begin
            n_fail++;
            $display("FAIL long_advance addr=%0d sync=%b expected 1/1", rom_addr, sync);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (sync !== 1'b0 || obj_bus !== f1) begin
            n_fail++;
            $display("FAIL long_second sync=%b obj=%h expected 0/%h", sync, obj_bus, f1);
        end
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        wait_done(50, ok);
        n_checks++;
        if (!ok || spawn_count !== 8'd2) begin
            n_fail++;
            $display("FAIL long_done done=%b spawn=%0d expected 1/2", done, spawn_count);
        end
    endtask

    task automatic test_full_rom();
        int  k;
        bit  prev_sync;
        bit  wrapped;
        for (int i = 0; i < DEPTH; i++)
            rom[i] = mk_rec(1'b0, 8'($urandom_range(0, 3)), rand_fields());
        do_start();
        k = 0;
        prev_sync = 1'b1;
        wrapped = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge clk);
            centi_tick = 1'($urandom_range(0, 1));
            if (!sync && prev_sync) begin
                n_checks++;
                if (k >= DEPTH || obj_bus !== rom[k][57:0] || rom_addr !== AW'(k)) begin
                    n_fail++;
                    $display("FAIL full_record idx=%0d addr=%0d obj=%h", k, rom_addr, obj_bus);
                end
                k++;
            end
            if (k >= 2 && rom_addr == '0) wrapped = 1'b1;
            prev_sync = sync;
            update = !sync;
        end
        centi_tick = 1'b0;
        update = 1'b0;
        n_checks++;
        if (done !== 1'b1 || k != DEPTH || spawn_count !== 8'd64) begin
            n_fail++;
            $display("FAIL full_done done=%b requests=%0d spawn=%0d expected 1/64/64", done, k, spawn_count);
        end
        n_checks++;
        if (rom_addr !== AW'(DEPTH - 1) || wrapped || drop_count !== 8'd0) begin
            n_fail++;
            $display("FAIL full_addr addr=%0d wrapped=%b drop=%0d expected 63/0/0", rom_addr, wrapped, drop_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [57:0] f;
        bit ok;
        fill_rom_end();
        f = rand_fields();
        rom[0] = mk_rec(1'b0, 8'd0, f);
        do_start();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sync !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_req sync=%b expected 0", sync);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (sync !== 1'b1 || busy !== 1'b0 || obj_bus !== '0 || rom_addr !== '0) begin
            n_fail++;
            $display("FAIL midreset_async sync=%b busy=%b obj=%h addr=%0d expected 1/0/0/0",
                     sync, busy, obj_bus, rom_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        do_start();
        n_checks++;
        if (rom_addr !== '0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_restart addr=%0d busy=%b expected 0/1", rom_addr, busy);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (sync !== 1'b0 || obj_bus !== f) begin
            n_fail++;
            $display("FAIL midreset_rerequest sync=%b obj=%h expected 0/%h", sync, obj_bus, f);
        end
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        wait_done(50, ok);
        n_checks++;
        if (!ok || spawn_count !== 8'd1) begin
            n_fail++;
            $display("FAIL midreset_done done=%b spawn=%0d expected 1/1", done, spawn_count);
        end
    endtask

    task automatic test_timeout();
        logic [57:0] f1;
        int low_cnt;
        bit ok;
        fill_rom_end();
        f1 = rand_fields();
        rom[0] = mk_rec(1'b0, 8'd0, rand_fields());
        rom[1] = mk_rec(1'b0, 8'd0, f1);
        do_start();
        repeat (3) @(negedge clk);
`ifdef SPAWN_TIMEOUT_EN
        low_cnt = 0;
        while (sync === 1'b0 && low_cnt < 100) begin
            low_cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (low_cnt != TO || drop_count !== 8'd1 || spawn_count !== 8'd0) begin
            n_fail++;
            $display("FAIL timeout_drop low_cycles=%0d drop=%0d spawn=%0d expected %0d/1/0",
                     low_cnt, drop_count, spawn_count, TO);
        end
        @(negedge clk);
        n_checks++;
        if (rom_addr !== AW'(1)) begin
            n_fail++;
            $display("FAIL timeout_next addr=%0d expected 1", rom_addr);
        end
        repeat (3) @(negedge clk);
`else
        low_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (sync === 1'b0) low_cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (low_cnt != 40 || drop_count !== 8'd0) begin
            n_fail++;
            $display("FAIL no_timeout low_cycles=%0d drop=%0d expected 40/0", low_cnt, drop_count);
        end
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        repeat (4) @(negedge clk);
`endif
        n_checks++;
        if (sync !== 1'b0 || obj_bus !== f1) begin
            n_fail++;
            $display("FAIL timeout_second sync=%b obj=%h expected 0/%h", sync, obj_bus, f1);
        end
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        wait_done(50, ok);
        n_checks++;
`ifdef SPAWN_TIMEOUT_EN
        if (!ok || spawn_count !== 8'd1 || drop_count !== 8'd1) begin
            n_fail++;
            $display("FAIL timeout_done done=%b spawn=%0d drop=%0d expected 1/1/1", done, spawn_count, drop_count);
        end
`else
        if (!ok || spawn_count !== 8'd2 || drop_count !== 8'd0) begin
            n_fail++;
            $display("FAIL timeout_done done=%b spawn=%0d drop=%0d expected 1/2/0", done, spawn_count, drop_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delay();
        test_long_ack();
        test_full_rom();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
